// File: rtl/bsg_link_sdr_tx_serializer_pkg.sv
// Shared types and helpers for the SDR link TX serializer.
package bsg_link_sdr_tx_serializer_pkg;

  typedef enum logic {e_idle, e_send} state_e;

  // Width of a flit counter that must hold 0..num_flits-1; never below one bit.
  function automatic int flit_cnt_width(input int num_flits);
    return (num_flits <= 2) ? 1 : $clog2(num_flits);
  endfunction

endpackage

// File: rtl/bsg_link_sdr_tx_flit_ctr.sv
// Flit counter: synchronous clear, increment that saturates at a dynamic limit,
// terminal-count flag when the count equals the limit.
module bsg_link_sdr_tx_flit_ctr #(
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic [width_p-1:0] limit_i,
  output logic [width_p-1:0] cnt_o,
  output logic               tc_o
);

  logic [width_p-1:0] cnt_q, cnt_d;

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == limit_i);

  // Next count: clear wins; increment stops at the limit so the count stays in range.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (inc_i && !tc_o) cnt_d = cnt_q + width_p'(1);
  end

  // Count register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bsg_link_sdr_tx_serializer.sv
// Packet-to-flit serializer feeding the SDR link uplink. One-entry packet
// buffer, flits sent LSB-first, back-to-back packets without a bubble.
// Optional macro BSG_LINK_SDR_TX_SERIALIZER_VARLEN_EN: the low bits of flit 0
// carry a length field and each packet sends min(len, last)+1 flits.
module bsg_link_sdr_tx_serializer
  import bsg_link_sdr_tx_serializer_pkg::*;
#(
  parameter int link_width_p = 32,
  parameter int num_flits_p  = 4,
  localparam int pkt_width_lp    = link_width_p * num_flits_p,
  localparam int lg_num_flits_lp = flit_cnt_width(num_flits_p)
) (
  input  logic                    core_clk_i,
  input  logic                    core_reset_n_i,
  input  logic                    pkt_v_i,
  input  logic [pkt_width_lp-1:0] pkt_data_i,
  output logic                    pkt_ready_and_o,
  output logic                    link_v_o,
  output logic [link_width_p-1:0] link_data_o,
  input  logic                    link_ready_and_i,
  output logic                    busy_o
);

  localparam logic [lg_num_flits_lp-1:0] last_lp = lg_num_flits_lp'(num_flits_p - 1);

  state_e state_q, state_d;
  logic [num_flits_p-1:0][link_width_p-1:0] buf_q, buf_d;
  logic [lg_num_flits_lp-1:0] flit_cnt, limit;
  logic cnt_clr, cnt_inc, cnt_tc, latch;

`ifdef BSG_LINK_SDR_TX_SERIALIZER_VARLEN_EN
  logic [lg_num_flits_lp-1:0] last_q, last_d, len;

  // Per-packet last index, clamped to the buffer depth.
  always_comb begin
    len    = pkt_data_i[lg_num_flits_lp-1:0];
    last_d = last_q;
    if (latch) last_d = (len > last_lp) ? last_lp : len;
  end

  // Latched last index for the packet in flight.
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) last_q <= '0;
    else                 last_q <= last_d;
  end

  assign limit = last_q;
`else
  assign limit = last_lp;
`endif

  // Next state, buffer load and counter control; ready depends combinationally
  // on link_ready_and_i so a new packet can land on the last flit's handshake.
  always_comb begin
    state_d         = state_q;
    buf_d           = buf_q;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    latch           = 1'b0;
    pkt_ready_and_o = 1'b0;
    case (state_q)
      e_idle: begin
        pkt_ready_and_o = 1'b1;
        if (pkt_v_i) begin
          latch   = 1'b1;
          state_d = e_send;
        end
      end
      e_send: begin
        if (link_ready_and_i) begin
          if (!cnt_tc) begin
            cnt_inc = 1'b1;
          end else begin
            pkt_ready_and_o = 1'b1;
            cnt_clr         = 1'b1;
            if (pkt_v_i) latch   = 1'b1;
            else         state_d = e_idle;
          end
        end
      end
      default: state_d = e_idle;
    endcase
    if (latch) begin
      buf_d   = pkt_data_i;
      cnt_clr = 1'b1;
    end
  end

  // State and packet buffer registers.
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state_q <= e_idle;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  bsg_link_sdr_tx_flit_ctr #(.width_p(lg_num_flits_lp)) u_ctr (
    .clk_i     (core_clk_i),
    .reset_n_i (core_reset_n_i),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .limit_i   (limit),
    .cnt_o     (flit_cnt),
    .tc_o      (cnt_tc)
  );

  assign link_v_o    = (state_q == e_send);
  assign busy_o      = link_v_o;
  assign link_data_o = buf_q[flit_cnt];

endmodule
